// File: rtl/inst_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package inst_cache_pkg;

  typedef enum logic {IDLE, FILL} state_t;

  localparam int INDEX_BITS_DEF  = 6;
  localparam int OFFSET_BITS_DEF = 2;
  localparam int ADDR_W_DEF      = 32;

  localparam int TAG_BITS = ADDR_W_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF - 2;
  localparam int WORDS    = 1 << OFFSET_BITS_DEF;

  // Tag width for an arbitrary geometry; byte offset within a word is always 2 bits.
  function automatic int tag_bits(input int addr_w, input int index_bits, input int offset_bits);
    return addr_w - index_bits - offset_bits - 2;
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write, bulk valid clear.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = INDEX_BITS_DEF,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF,
  parameter int TAG_W       = TAG_BITS,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_all,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   tag_we,
  input  logic [TAG_W-1:0]       tag_wdata,
  input  logic                   set_valid
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int NWORDS = 1 << OFFSET_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*NWORDS];

  // Only the valid bits need reset; tag/data are don't-care until validated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           valid <= '0;
    else if (clr_all)   valid <= '0;
    else if (set_valid) valid[wr_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[wr_index] <= tag_wdata;
    if (wr_en)  data_mem[{wr_index, wr_offset}] <= wr_data;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, in-order line fill on miss.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS  = INDEX_BITS_DEF,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pcF,
  output logic [31:0]       instrF,
  output logic              stallF,
  input  logic              inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       miss_count
);

  localparam int TAG_W  = tag_bits(ADDR_W, INDEX_BITS, OFFSET_BITS);
  localparam int NWORDS = 1 << OFFSET_BITS;
  localparam int LINE_W = ADDR_W - OFFSET_BITS - 2;

  state_t                 state, state_nx;
  logic [OFFSET_BITS-1:0] beat;
  logic [LINE_W-1:0]      line;
  logic                   poison;
  logic                   start_fill, ack_beat, last_ack;

  logic [TAG_W-1:0]       pc_tag;
  logic [INDEX_BITS-1:0]  pc_index;
  logic [OFFSET_BITS-1:0] pc_off;
  logic                   unused_pc;

  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [31:0]            rd_data;
  logic                   hit;

  assign pc_tag    = pcF[ADDR_W-1 -: TAG_W];
  assign pc_index  = pcF[OFFSET_BITS+2 +: INDEX_BITS];
  assign pc_off    = pcF[2 +: OFFSET_BITS];
  assign unused_pc = ^pcF[1:0];

  inst_cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (32)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (inv),
    .rd_index (pc_index),
    .rd_offset(pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (ack_beat),
    .wr_index (line[INDEX_BITS-1:0]),
    .wr_offset(beat),
    .wr_data  (mem_rdata),
    .tag_we   (last_ack),
    .tag_wdata(line[LINE_W-1 -: TAG_W]),
    // inv on the final beat must win, as must any inv seen earlier in the fill
    .set_valid(last_ack && !poison && !inv)
  );

  assign hit    = rd_valid && (rd_tag == pc_tag) && (state == IDLE);
  assign instrF = hit ? rd_data : 32'h0;
  assign stallF = ~hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_fill = 1'b0;
    ack_beat   = 1'b0;
    last_ack   = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        // a miss coinciding with inv only invalidates; the fetch re-misses next cycle
        if (!hit && !inv) begin
          state_nx   = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {line, beat, 2'b00};
        if (mem_ack) begin
          ack_beat = 1'b1;
          if (beat == OFFSET_BITS'(NWORDS-1)) begin
            last_ack = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat       <= '0;
      line       <= '0;
      poison     <= 1'b0;
      miss_count <= '0;
    end else begin
      if (start_fill) begin
        line <= pcF[ADDR_W-1:OFFSET_BITS+2];
        beat <= '0;
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end else if (ack_beat) begin
        beat <= beat + 1'b1;
      end
      if (state == FILL) begin
        if (last_ack) poison <= 1'b0;
        else if (inv) poison <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache with a memory responder and an expected-instruction scoreboard.
module tb_inst_cache;

  logic        clk, rst, inv, mem_ack;
  logic [31:0] pcF, mem_rdata;
  logic [31:0] instrF, mem_addr, miss_count;
  logic        stallF, mem_req;

  int vectors = 0;
  int miscompares = 0;
  int ack_every = 1;

  logic [31:0] sb[$];
  logic [31:0] log_q[$];

  inst_cache dut (
    .clk(clk), .rst(rst), .pcF(pcF), .instrF(instrF), .stallF(stallF), .inv(inv),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: data equals address, ack every ack_every-th requesting cycle.
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        cnt++;
        mem_ack   = (cnt % ack_every) == 0;
        mem_rdata = mem_addr;
      end else begin
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  // Bus monitor just before each rising edge: log accepted beats, check hold while unacked.
  initial begin
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      if (rst && mem_req) begin
        if (prev_req && !prev_ack) check("addr_hold", mem_addr, prev_addr);
        if (mem_ack) log_q.push_back(mem_addr);
      end
      prev_req  = mem_req & rst;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  end

  // Apply a fetch (also releasing reset), count stalled cycles, score the delivered word.
  task automatic fetch(input string tag, input logic [31:0] pc, output int stalls);
    logic [31:0] exp;
    bit done = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    pcF = pc;
    sb.push_back({pc[31:2], 2'b00});
    stalls = 0;
    while (!done) begin
      @(negedge clk);
      if (!stallF) done = 1;
      else if (stalls == 60) begin
        vectors++;
        miscompares++;
        $error("FAIL %s_timeout: observed stall > %0d expected hit", tag, stalls);
        done = 1;
      end else stalls++;
    end
    exp = sb.pop_front();
    check({tag, "_instr"}, instrF, exp);
  endtask

  task automatic check_log(input string tag, input int base, input logic [31:0] start);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = (base + i < log_q.size()) ? log_q[base+i] : 32'hDEAD_BEEF;
      check(tag, v, start + 32'(4*i));
    end
  endtask

  initial begin
    int st;
    rst = 1'b0; inv = 1'b0; pcF = 32'h0;
    #3;
    check("rst_stall", {31'b0, stallF}, 32'd1);
    check("rst_instr", instrF, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_miss", miss_count, 32'd0);

    // cold miss
    log_q.delete();
    fetch("cold", 32'h40, st);
    check("cold_stalls", 32'(st), 32'd5);
    check("cold_log_n", 32'(log_q.size()), 32'd4);
    check_log("cold_addr", 0, 32'h40);
    check("cold_miss", miss_count, 32'd1);

    // hit within line
    fetch("hit", 32'h4C, st);
    check("hit_stalls", 32'(st), 32'd0);
    check("hit_noreq", {31'b0, mem_req}, 32'd0);
    check("hit_miss", miss_count, 32'd1);

    // conflict eviction
    log_q.delete();
    fetch("evict", 32'h1040, st);
    check("evict_stalls", 32'(st), 32'd5);
    check_log("evict_addr", 0, 32'h1040);
    check("evict_miss", miss_count, 32'd2);
    fetch("remiss", 32'h40, st);
    check("remiss_stalls", 32'(st), 32'd5);
    check("remiss_miss", miss_count, 32'd3);

    // wait states
    ack_every = 3;
    log_q.delete();
    fetch("wait", 32'h3000, st);
    check("wait_stalls", 32'(st), 32'd13);
    check("wait_log_n", 32'(log_q.size()), 32'd4);
    check_log("wait_addr", 0, 32'h3000);
    check("wait_miss", miss_count, 32'd4);
    ack_every = 1;
    fetch("wait_hit", 32'h300C, st);
    check("wait_hit_stalls", 32'(st), 32'd0);

    // inv on beat 2: handshake completes, line stays invalid, refilled again
    log_q.delete();
    fork
      fetch("inv", 32'h2000, st);
      begin
        int n = 0;
        @(posedge clk);
        #1;
        while (log_q.size() < 2 && n < 40) begin
          @(posedge clk);
          #1;
          n++;
        end
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
      end
    join
    check("inv_stalls", 32'(st), 32'd10);
    check("inv_log_n", 32'(log_q.size()), 32'd8);
    check_log("inv_addr1", 0, 32'h2000);
    check_log("inv_addr2", 4, 32'h2000);
    check("inv_miss", miss_count, 32'd6);
    fetch("inv_hit", 32'h2004, st);
    check("inv_hit_stalls", 32'(st), 32'd0);

    // reset during beat 1
    log_q.delete();
    @(posedge clk);
    #1;
    pcF = 32'h40;
    begin
      int n = 0;
      @(posedge clk);
      #1;
      while (log_q.size() < 1 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    #1 rst = 1'b0;
    #1;
    check("rstf_req", {31'b0, mem_req}, 32'd0);
    check("rstf_addr", mem_addr, 32'h0);
    check("rstf_miss", miss_count, 32'd0);
    check("rstf_stall", {31'b0, stallF}, 32'd1);
    log_q.delete();
    fetch("after_rst", 32'h40, st);
    check("after_rst_stalls", 32'(st), 32'd5);
    check_log("after_rst_addr", 0, 32'h40);
    check("after_rst_miss", miss_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch port (pcF/instrF) and the external instruction memory.
- On a hit it returns instrF in the same cycle, combinationally, so the core's fetch timing is unchanged.
- On a miss it raises stallF and runs a line fill over a req/ack memory bus.
- It then serves the fetch from the refilled line.

Parameters:
- INDEX_BITS, 6, line-index width (64 lines).
- OFFSET_BITS, 2, word-offset width (4 words per line).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pcF  in  32  fetch byte address from core.
- instrF  out  32  instruction to core; valid when stallF=0.
- stallF  out  1  fetch stall request to core hazard logic.
- inv  in  1  invalidate all lines (fence.i-style), one-cycle pulse.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  32  word-aligned read address; stable while mem_req=1.
- mem_ack  in  1  beat accepted; mem_rdata valid in same cycle.
- mem_rdata  in  32  read data.
- miss_count  out  32  saturating count of misses, for performance monitoring.

Behaviour:
- Address split: tag=pcF[31:INDEX_BITS+OFFSET_BITS+2]; index=next INDEX_BITS; offset=next OFFSET_BITS; pcF[1:0] ignored.
- Arrays: valid[2^INDEX_BITS], tag[2^INDEX_BITS], data[2^INDEX_BITS][2^OFFSET_BITS]. Reads are asynchronous, writes synchronous.
- hit = valid[index] && tag[index]==tag(pcF) && state==IDLE.
- Outputs:
  - instrF = hit ? data[index][offset] : 32'h0 (NOP).
  - stallF = ~hit.
- Reset (rst=0, async):
  - state=IDLE, all valid=0, beat=0, miss_count=0, mem_req=0, mem_addr=0.
  - instrF=0, stallF=1.
- FSM states: IDLE, FILL.
  - IDLE, miss and inv=0: latch line address {pcF[31:OFFSET_BITS+2],0}, beat=0, go FILL.
  - IDLE, miss and inv=1: invalidate only; stay IDLE; the miss is taken next cycle.
  - FILL: mem_req=1, mem_addr=line_addr+4*beat. On mem_ack, write mem_rdata into data[line_index][beat] and increment beat.
  - FILL, ack on the last beat (beat==2^OFFSET_BITS-1): write tag, set valid unless poisoned, go IDLE.
  - FILL, no ack: hold mem_req and mem_addr; beat unchanged.
- Fill order: word 0 upward, no critical-word-first. Latched line address is authoritative; pcF changes during FILL are ignored.
- Latency: zero-wait memory (ack every cycle) gives miss penalty 1+2^OFFSET_BITS cycles. Default is 5: miss detected cycle 0, beats cycles 1-4, hit cycle 5.
- miss_count increments on each IDLE->FILL transition and saturates at 32'hFFFF_FFFF.
- inv:
  - Clears all valid bits at the next edge.
  - If inv is asserted in FILL, the fill is not abandoned (bus handshake completes), but the line is poisoned: valid is not set at completion. The poison flag clears on entering IDLE.
- Simultaneous events:
  - inv on the same edge as the last ack: the line is not validated.
  - rst mid-fill: immediate abort. mem_req drops asynchronously; the memory side must tolerate a dropped request.
- Tag match is exact on all tag bits. There is no parity checking.

Decomposition:
- Package inst_cache_pkg holds:
  - state enum {IDLE, FILL};
  - derived constants TAG_BITS=ADDR_W-INDEX_BITS-OFFSET_BITS-2 and WORDS=1<<OFFSET_BITS.
- One sub-module, inst_cache_array: valid/tag/data storage, async read port and one write port, plus a clear-all-valid input driven by rst or inv.
- FSM, counters and the hit compare stay in inst_cache.

Test Plan:
- Cold miss: reset, pcF=0x0000_0040, zero-wait memory returning data=address.
  - stallF=1 for cycles 0-4.
  - mem_addr sequence 0x40,0x44,0x48,0x4C.
  - Cycle 5: stallF=0, instrF=0x40, miss_count=1.
- Hit within line: after the cold miss, pcF=0x4C -> same cycle instrF=0x4C, stallF=0, no mem_req.
- Conflict eviction:
  - pcF=0x0000_1040 (same index, different tag) -> refill 0x1040..0x104C, miss_count=2.
  - Then pcF=0x40 -> miss again, miss_count=3.
- Wait states: mem_ack every 3rd cycle -> mem_req and mem_addr held stable between acks; fill completes after 12 cycles; data correct.
- inv during fill: pulse inv on beat 2 -> all 4 beats still fetched; line not valid; immediate re-miss and second fill; then hit.
- Reset mid-fill: drop rst on beat 1 -> mem_req=0 asynchronously, miss_count=0. After release, pcF=0x40 misses and refills from word 0.
